gat_host_if_ctrl: RTL and testbench
===================================

Name: gat_host_if_ctrl

Overview:
Host-side control front-end between the PS register bank/BRAM ports and gat_top.
- Decodes byte-addressed 32-bit host writes onto NUM_CH load channels.
- Sequences load, start, run and done with a layer handshake to the core.
- Times each run and exposes debug/status words.
- Returns feature readback data with a fixed-latency valid strobe.

Parameters:
TOP_WIDTH, 32, host data/debug word width
NUM_CH, 3, number of load channels (h_data, h_node_info, wgt)
CH_SEL_W, 2, channel select width (>= clog2(NUM_CH))
CH_DATA_WIDTH, 20, payload bits forwarded per write (wr_din[CH_DATA_WIDTH-1:0])
CH_ADDR_W, 18, channel word-address width
FEAT_ADDR_W, 16, feature word-address width
FEAT_WIDTH, 32, feature data width
RD_LATENCY, 2, core feature BRAM read latency in cycles (>= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  host write strobe
wr_ch_sel  in  CH_SEL_W  target channel
wr_addr  in  CH_ADDR_W+2  byte address
wr_din  in  TOP_WIDTH  write data
ch_wr_en  out  NUM_CH  one-hot registered write enable
ch_wr_addr  out  CH_ADDR_W  registered word address (wr_addr[CH_ADDR_W+1:2])
ch_wr_din  out  CH_DATA_WIDTH  registered payload
load_done  in  NUM_CH  per-channel load-complete levels from register bank
gat_layer  in  1  layer select for next run
gat_start  in  1  run request pulse
gat_ready  out  1  ready for start / results valid
core_start  out  1  single-cycle start to core
core_layer  out  1  layer latched at start
core_done  in  1  core completion pulse
feat_rd_en  in  1  readback request
feat_rd_addr  in  FEAT_ADDR_W+2  readback byte address
core_feat_addr  out  FEAT_ADDR_W  word address to core (combinational, feat_rd_addr[FEAT_ADDR_W+1:2])
core_feat_dout  in  FEAT_WIDTH  core read data
feat_rd_valid  out  1  data-valid strobe
feat_rd_data  out  FEAT_WIDTH  readback data
gat_debug_1  out  TOP_WIDTH  cycles of last completed run
gat_debug_2  out  TOP_WIDTH  accepted write count
gat_debug_3  out  TOP_WIDTH  status word

Behaviour:
Reset: all outputs 0, state LOAD, counters 0, error flags 0.

State machine (2-bit state encoding):
- LOAD (0) -> ARMED (1) when &load_done.
- ARMED -> RUN (2) on gat_start.
- RUN -> DONE (3) on core_done.
- DONE -> RUN on gat_start (re-run without reload, e.g. layer 2).
- ARMED/DONE -> LOAD when any load_done bit is 0. This has priority over a simultaneous gat_start; that start is dropped and sets err_start.

Outputs by state:
- gat_ready = 1 in ARMED and DONE only. It is registered and reflects the current state.
- On every RUN entry: core_start = 1 for exactly one cycle, and core_layer <= gat_layer sampled that cycle. core_layer then holds until the next start.

Write path:
- A write is accepted when wr_en=1, state = LOAD, wr_ch_sel < NUM_CH, and wr_addr[1:0] == 0.
- An accepted write drives ch_wr_en[wr_ch_sel], ch_wr_addr and ch_wr_din one cycle later.
- Rejected writes produce no ch_wr_en and set a sticky flag:
  - err_state for a write outside LOAD;
  - err_sel for an out-of-range channel;
  - err_align for a misaligned address.
- gat_debug_2 increments per accepted write, saturating at all-ones. It clears on any transition into LOAD from ARMED or DONE.

Run timer:
- Counter clears on RUN entry and increments each RUN cycle, saturating at all-ones.
- On the core_done cycle, gat_debug_1 <= counter+1 (saturated). The count includes the start cycle.
- core_done outside RUN is ignored and sets err_done.

Error handling:
- gat_start in LOAD or RUN is ignored and sets err_start.
- All error flags clear on an accepted start (RUN entry), except any flag set in that same cycle.

gat_debug_3 layout:
- [1:0] state
- [2] err_state, [3] err_sel, [4] err_align, [5] err_start, [6] err_done
- [7] core_layer
- [7+NUM_CH:8] load_done
- remaining bits 0

Readback:
- Accepted in any state.
- feat_rd_valid follows feat_rd_en by RD_LATENCY cycles through a shift pipe, with feat_rd_data = core_feat_dout sampled when valid asserts.
- Back-to-back requests are supported at 1 per cycle.
- Reset flushes the pipe.

Reset mid-run returns to LOAD with outputs zeroed.

Test Plan:
- Reset, then set load_done=3'b111 -> state ARMED next cycle, gat_ready=1, gat_debug_3[1:0]=1.
- In LOAD, write ch 1, addr 0x10, din 0xFFFFF123 -> next cycle ch_wr_en=3'b010, ch_wr_addr=4, ch_wr_din=0xFF123 (CH_DATA_WIDTH=20), gat_debug_2=1.
- Write addr 0x11 on ch 3; then a write while ARMED -> no ch_wr_en, debug_3[4:2]=3'b111, debug_2 unchanged.
- ARMED, gat_layer=1, gat_start; core_done 100 cycles after core_start -> core_start high 1 cycle, core_layer=1, DONE, gat_debug_1=101, errors cleared.
- DONE, load_done[0] falls while gat_start=1 -> state LOAD, no core_start, err_start=1, gat_debug_2=0.
- RD_LATENCY=2, feat_rd_en for 3 cycles at byte addrs 0,4,8 -> core_feat_addr 0,1,2; feat_rd_valid high cycles 2-4 with matching data.

Source files
------------

// File: rtl/gat_host_if_ctrl.sv
// gat_host_if_ctrl: host write decode, run sequencing,
// run timing, status words and feature readback for gat_top.
module gat_host_if_ctrl #(
  parameter int TOP_WIDTH     = 32,
  parameter int NUM_CH        = 3,
  parameter int CH_SEL_W      = 2,
  parameter int CH_DATA_WIDTH = 20,
  parameter int CH_ADDR_W     = 18,
  parameter int FEAT_ADDR_W   = 16,
  parameter int FEAT_WIDTH    = 32,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_SEL_W-1:0]      wr_ch_sel,
  input  logic [CH_ADDR_W+1:0]     wr_addr,
  input  logic [TOP_WIDTH-1:0]     wr_din,
  output logic [NUM_CH-1:0]        ch_wr_en,
  output logic [CH_ADDR_W-1:0]     ch_wr_addr,
  output logic [CH_DATA_WIDTH-1:0] ch_wr_din,
  input  logic [NUM_CH-1:0]        load_done,
  input  logic                     gat_layer,
  input  logic                     gat_start,
  output logic                     gat_ready,
  output logic                     core_start,
  output logic                     core_layer,
  input  logic                     core_done,
  input  logic                     feat_rd_en,
  input  logic [FEAT_ADDR_W+1:0]   feat_rd_addr,
  output logic [FEAT_ADDR_W-1:0]   core_feat_addr,
  input  logic [FEAT_WIDTH-1:0]    core_feat_dout,
  output logic                     feat_rd_valid,
  output logic [FEAT_WIDTH-1:0]    feat_rd_data,
  output logic [TOP_WIDTH-1:0]     gat_debug_1,
  output logic [TOP_WIDTH-1:0]     gat_debug_2,
  output logic [TOP_WIDTH-1:0]     gat_debug_3
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state, nxt;
  logic                  all_loaded;
  logic                  start_acc;
  logic                  to_load;
  logic                  in_load;
  logic                  sel_ok;
  logic                  align_ok;
  logic                  wr_acc;
  logic [4:0]            err, err_set;
  logic [TOP_WIDTH-1:0]  wr_cnt;
  logic [TOP_WIDTH-1:0]  run_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  unused_bits;

  assign unused_bits = ^{wr_din[TOP_WIDTH-1:CH_DATA_WIDTH],
                         feat_rd_addr[1:0]};

  assign all_loaded = &load_done;

  always_comb begin
    nxt       = state;
    start_acc = 1'b0;
    unique case (state)
      S_LOAD:  if (all_loaded) nxt = S_ARMED;
      S_ARMED,
      S_DONE: begin
        // A falling load_done wins over a same-cycle start.
        if (!all_loaded) begin
          nxt = S_LOAD;
        end else if (gat_start) begin
          nxt       = S_RUN;
          start_acc = 1'b1;
        end
      end
      S_RUN:   if (core_done) nxt = S_DONE;
      default: nxt = S_LOAD;
    endcase
  end

  assign to_load  = (state == S_ARMED || state == S_DONE) &&
                    (nxt == S_LOAD);
  assign in_load  = (state == S_LOAD);
  assign sel_ok   = 32'(wr_ch_sel) < NUM_CH;
  assign align_ok = (wr_addr[1:0] == 2'b00);
  assign wr_acc   = wr_en && in_load && sel_ok && align_ok;

  // {done, start, align, sel, state}
  assign err_set = {
    core_done && (state != S_RUN),
    gat_start && !start_acc,
    wr_en && !align_ok,
    wr_en && !sel_ok,
    wr_en && !in_load
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      gat_ready  <= 1'b0;
      core_start <= 1'b0;
      core_layer <= 1'b0;
      err        <= '0;
    end else begin
      state      <= nxt;
      gat_ready  <= (nxt == S_ARMED) || (nxt == S_DONE);
      core_start <= start_acc;
      if (start_acc) core_layer <= gat_layer;
      err <= start_acc ? err_set : (err | err_set);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_wr_en   <= '0;
      ch_wr_addr <= '0;
      ch_wr_din  <= '0;
      wr_cnt     <= '0;
    end else begin
      ch_wr_en <= wr_acc ? (NUM_CH'(1) << wr_ch_sel) : '0;
      if (wr_acc) begin
        ch_wr_addr <= wr_addr[CH_ADDR_W+1:2];
        ch_wr_din  <= wr_din[CH_DATA_WIDTH-1:0];
      end
      if (to_load) wr_cnt <= '0;
      else if (wr_acc && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // run_cnt is 0 in the start cycle, so done reports run_cnt+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      gat_debug_1 <= '0;
    end else begin
      if (start_acc) run_cnt <= '0;
      else if (state == S_RUN && run_cnt != '1)
        run_cnt <= run_cnt + 1'b1;
      if (state == S_RUN && core_done)
        gat_debug_1 <= (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= feat_rd_en;
      for (int i = 1; i < RD_LATENCY; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign core_feat_addr = feat_rd_addr[FEAT_ADDR_W+1:2];
  assign feat_rd_valid  = rd_pipe[RD_LATENCY-1];
  assign feat_rd_data   = feat_rd_valid ? core_feat_dout : '0;

  assign gat_debug_2 = wr_cnt;
  assign gat_debug_3 = TOP_WIDTH'({load_done, core_layer, err, state});

endmodule

// File: tb/tb_gat_host_if_ctrl.sv
// Directed self-checking bench for gat_host_if_ctrl.
// Each task drives one scenario and checks inline.
module tb_gat_host_if_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch_sel;
  logic [19:0] wr_addr;
  logic [31:0] wr_din;
  logic [2:0]  ch_wr_en;
  logic [17:0] ch_wr_addr;
  logic [19:0] ch_wr_din;
  logic [2:0]  load_done;
  logic        gat_layer;
  logic        gat_start;
  logic        gat_ready;
  logic        core_start;
  logic        core_layer;
  logic        core_done;
  logic        feat_rd_en;
  logic [17:0] feat_rd_addr;
  logic [15:0] core_feat_addr;
  logic [31:0] core_feat_dout;
  logic        feat_rd_valid;
  logic [31:0] feat_rd_data;
  logic [31:0] gat_debug_1;
  logic [31:0] gat_debug_2;
  logic [31:0] gat_debug_3;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram_d1, bram_d2;

  always #5 clk = ~clk;

  // Core BRAM model: two-cycle read latency.
  always @(posedge clk) begin
    bram_d1 <= 32'hC0DE_0000 | {16'h0, core_feat_addr};
    bram_d2 <= bram_d1;
  end
  assign core_feat_dout = bram_d2;

  gat_host_if_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ch_sel(wr_ch_sel),
    .wr_addr(wr_addr), .wr_din(wr_din),
    .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr),
    .ch_wr_din(ch_wr_din), .load_done(load_done),
    .gat_layer(gat_layer), .gat_start(gat_start),
    .gat_ready(gat_ready), .core_start(core_start),
    .core_layer(core_layer), .core_done(core_done),
    .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr),
    .core_feat_addr(core_feat_addr),
    .core_feat_dout(core_feat_dout),
    .feat_rd_valid(feat_rd_valid), .feat_rd_data(feat_rd_data),
    .gat_debug_1(gat_debug_1), .gat_debug_2(gat_debug_2),
    .gat_debug_3(gat_debug_3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_ch_sel = 0; wr_addr = 0;
    wr_din = 0; load_done = 0; gat_layer = 0; gat_start = 0;
    core_done = 0; feat_rd_en = 0; feat_rd_addr = 0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (gat_debug_3 !== 32'h0) begin errors++;
      $display("FAIL reset_dbg3 got %h exp 0", gat_debug_3); end
    checks++;
    if ({gat_ready, core_start, core_layer, feat_rd_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000",
        {gat_ready, core_start, core_layer, feat_rd_valid}); end
    checks++;
    if (ch_wr_en !== 3'b0 || gat_debug_1 !== 0 || gat_debug_2 !== 0) begin
      errors++; $display("FAIL reset_regs got %b %h %h exp 0",
        ch_wr_en, gat_debug_1, gat_debug_2); end
  endtask

  task automatic test_write();
    wr_en = 1; wr_ch_sel = 1; wr_addr = 20'h10; wr_din = 32'hFFFF_F123;
    step();
    wr_en = 0;
    checks++;
    if (ch_wr_en !== 3'b010) begin errors++;
      $display("FAIL wr_en got %b exp 010", ch_wr_en); end
    checks++;
    if (ch_wr_addr !== 18'd4 || ch_wr_din !== 20'hFF123) begin errors++;
      $display("FAIL wr_data got %h %h exp 4 ff123",
        ch_wr_addr, ch_wr_din); end
    checks++;
    if (gat_debug_2 !== 32'd1) begin errors++;
      $display("FAIL wr_cnt1 got %0d exp 1", gat_debug_2); end
    step();
    checks++;
    if (ch_wr_en !== 3'b000) begin errors++;
      $display("FAIL wr_en_pulse got %b exp 000", ch_wr_en); end
    wr_en = 1; wr_ch_sel = 0; wr_addr = 20'h8; wr_din = 32'h000A_BCDE;
    step();
    wr_en = 0;
    checks++;
    if (ch_wr_en !== 3'b001 || ch_wr_addr !== 18'd2 ||
        ch_wr_din !== 20'hABCDE || gat_debug_2 !== 32'd2) begin
      errors++; $display("FAIL wr_ch0 got %b %h %h %0d exp 001 2 abcde 2",
        ch_wr_en, ch_wr_addr, ch_wr_din, gat_debug_2); end
  endtask

  task automatic test_reject();
    wr_en = 1; wr_ch_sel = 3; wr_addr = 20'h11; wr_din = 32'h5;
    step();
    wr_en = 0;
    checks++;
    if (ch_wr_en !== 3'b000 || gat_debug_3[4:2] !== 3'b110) begin
      errors++; $display("FAIL rej_sel_align got %b %b exp 000 110",
        ch_wr_en, gat_debug_3[4:2]); end
    load_done = 3'b111;
    step();
    checks++;
    if (gat_debug_3[1:0] !== 2'd1 || gat_ready !== 1'b1) begin errors++;
      $display("FAIL arm got %0d %b exp 1 1",
        gat_debug_3[1:0], gat_ready); end
    checks++;
    if (gat_debug_3[10:8] !== 3'b111) begin errors++;
      $display("FAIL dbg3_ld got %b exp 111", gat_debug_3[10:8]); end
    wr_en = 1; wr_ch_sel = 0; wr_addr = 20'h0;
    step();
    wr_en = 0;
    checks++;
    if (ch_wr_en !== 3'b000 || gat_debug_3[4:2] !== 3'b111 ||
        gat_debug_2 !== 32'd2) begin
      errors++; $display("FAIL rej_state got %b %b %0d exp 000 111 2",
        ch_wr_en, gat_debug_3[4:2], gat_debug_2); end
  endtask

  task automatic test_run();
    gat_layer = 1; gat_start = 1;
    step();
    gat_start = 0; gat_layer = 0;
    checks++;
    if (core_start !== 1'b1 || core_layer !== 1'b1) begin errors++;
      $display("FAIL start got %b %b exp 1 1", core_start, core_layer); end
    checks++;
    if (gat_debug_3[1:0] !== 2'd2 || gat_ready !== 1'b0 ||
        gat_debug_3[6:2] !== 5'b0) begin
      errors++; $display("FAIL run_state got %0d %b %b exp 2 0 0",
        gat_debug_3[1:0], gat_ready, gat_debug_3[6:2]); end
    step();
    checks++;
    if (core_start !== 1'b0) begin errors++;
      $display("FAIL start_pulse got %b exp 0", core_start); end
    repeat (99) step();
    core_done = 1;
    step();
    core_done = 0;
    checks++;
    if (gat_debug_1 !== 32'd101) begin errors++;
      $display("FAIL run_cycles got %0d exp 101", gat_debug_1); end
    checks++;
    if (gat_debug_3[1:0] !== 2'd3 || gat_ready !== 1'b1 ||
        core_layer !== 1'b1) begin
      errors++; $display("FAIL done_state got %0d %b %b exp 3 1 1",
        gat_debug_3[1:0], gat_ready, core_layer); end
    core_done = 1;
    step();
    core_done = 0;
    checks++;
    if (gat_debug_3[6] !== 1'b1 || gat_debug_1 !== 32'd101) begin
      errors++; $display("FAIL err_done got %b %0d exp 1 101",
        gat_debug_3[6], gat_debug_1); end
  endtask

  task automatic test_back_to_back();
    gat_layer = 0; gat_start = 1;
    step();
    gat_start = 0; core_done = 1;
    checks++;
    if (core_start !== 1'b1 || core_layer !== 1'b0 ||
        gat_debug_3[6:2] !== 5'b0) begin
      errors++; $display("FAIL rerun got %b %b %b exp 1 0 0",
        core_start, core_layer, gat_debug_3[6:2]); end
    step();
    core_done = 0;
    checks++;
    if (gat_debug_1 !== 32'd1 || gat_debug_3[1:0] !== 2'd3) begin
      errors++; $display("FAIL short_run got %0d %0d exp 1 3",
        gat_debug_1, gat_debug_3[1:0]); end
  endtask

  task automatic test_drop();
    load_done = 3'b110; gat_start = 1;
    step();
    gat_start = 0;
    checks++;
    if (gat_debug_3[1:0] !== 2'd0 || core_start !== 1'b0 ||
        gat_ready !== 1'b0) begin
      errors++; $display("FAIL drop_state got %0d %b %b exp 0 0 0",
        gat_debug_3[1:0], core_start, gat_ready); end
    checks++;
    if (gat_debug_3[5] !== 1'b1 || gat_debug_2 !== 32'd0) begin
      errors++; $display("FAIL drop_err got %b %0d exp 1 0",
        gat_debug_3[5], gat_debug_2); end
  endtask

  task automatic test_readback();
    for (int i = 0; i < 7; i++) begin
      feat_rd_en = (i < 3);
      feat_rd_addr = 18'(4 * i);
      #1;
      if (i < 3) begin
        checks++;
        if (core_feat_addr !== 16'(i)) begin errors++;
          $display("FAIL rd_addr%0d got %0d exp %0d",
            i, core_feat_addr, i); end
      end
      checks++;
      if (feat_rd_valid !== (i >= 2 && i <= 4)) begin errors++;
        $display("FAIL rd_valid%0d got %b exp %b",
          i, feat_rd_valid, (i >= 2 && i <= 4)); end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (feat_rd_data !== (32'hC0DE_0000 | 32'(i - 2))) begin
          errors++; $display("FAIL rd_data%0d got %h exp %h", i,
            feat_rd_data, 32'hC0DE_0000 | 32'(i - 2)); end
      end
      step();
    end
    feat_rd_en = 0;
  endtask

  task automatic test_reset_midrun();
    load_done = 3'b111;
    step();
    gat_layer = 1; gat_start = 1;
    step();
    gat_start = 0; feat_rd_en = 1;
    step();
    feat_rd_en = 0; rst = 1;
    step();
    rst = 0;
    checks++;
    if (gat_debug_3[1:0] !== 2'd0 || core_layer !== 1'b0 ||
        gat_ready !== 1'b0 || gat_debug_1 !== 32'd0) begin
      errors++; $display("FAIL mid_reset got %0d %b %b %0d exp 0 0 0 0",
        gat_debug_3[1:0], core_layer, gat_ready, gat_debug_1); end
    step();
    checks++;
    if (feat_rd_valid !== 1'b0) begin errors++;
      $display("FAIL pipe_flush got %b exp 0", feat_rd_valid); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_reject();
    test_run();
    test_back_to_back();
    test_drop();
    test_readback();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
